// File: rtl/adc_frame_packer_if.sv
// AXI4-Stream style output bundle of the ADC frame packer: 32-bit packed sample
// pairs with a frame-last marker.
interface adc_frame_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/adc_frame_packer.sv
// Packs gearbox sample pairs into 32-bit words, groups them into fixed-length frames
// and releases only fully committed frames on the stream port; overflowing frames are dropped whole.
module adc_frame_packer #(
    parameter int DATA_WIDTH  = 12,
    parameter int FRAME_WORDS = 256,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic                  dco_div4,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    adc_frame_packer_if.master    m_axis,
    output logic [15:0]           drop_cnt,
    output logic                  overflow_sticky,
    input  logic                  clear_status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FRAME_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
    localparam logic [PW-1:0] FULL_OCC = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    function automatic logic [15:0] pad16(input logic [DATA_WIDTH-1:0] s);
        return 16'(s);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t                state;
    logic                  half;
    logic [CW-1:0]         word_cnt;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         commit_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] s_even_p0;
    logic [32:0]           mem [FIFO_DEPTH];
    logic [32:0]           out_word_p1;

    logic          accept;
    logic          word_done;
    logic          frame_end;
    logic [PW-1:0] occupancy;
    logic          fifo_full;
    logic          wr_en;
    logic          rd_fire;
    logic [PW-1:0] rd_ptr_nxt;
    logic [31:0]   packed_word;
    state_t        after_frame;

    assign accept      = data_valid_in && (state != IDLE);
    assign word_done   = accept && half;
    assign frame_end   = (word_cnt == LAST_IDX);
    // Occupancy counts uncommitted words too and is taken before this cycle's read.
    assign occupancy   = wr_ptr - rd_ptr;
    assign fifo_full   = (occupancy == FULL_OCC);
    assign wr_en       = word_done && (state == RUN) && !fifo_full;
    assign packed_word = {pad16(data_in), pad16(s_even_p0)};
    assign after_frame = enable ? RUN : IDLE;

    assign m_axis.tvalid = (rd_ptr != commit_ptr);
    assign rd_fire       = m_axis.tvalid && m_axis.tready;
    assign rd_ptr_nxt    = rd_ptr + {{AW{1'b0}}, rd_fire};
    assign m_axis.tdata  = out_word_p1[31:0];
    assign m_axis.tlast  = out_word_p1[32];

    // Stage p0: even-sample holding register and FIFO storage
    always_ff @(posedge dco_div4) begin
        if (accept && !half) begin
            s_even_p0 <= data_in;
        end
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {frame_end, packed_word};
        end
    end

    // Stage p1: control FSM, pointers, status and registered read word
    always_ff @(posedge dco_div4) begin
        if (rst) begin
            state           <= IDLE;
            half            <= 1'b0;
            word_cnt        <= '0;
            wr_ptr          <= '0;
            commit_ptr      <= '0;
            rd_ptr          <= '0;
            out_word_p1     <= '0;
            drop_cnt        <= '0;
            overflow_sticky <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr_nxt;
            // Refreshed every cycle so the word at rd_ptr falls through without a bubble.
            out_word_p1 <= mem[rd_ptr_nxt[AW-1:0]];

            if (accept) begin
                half <= ~half;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (word_done) begin
                        if (fifo_full) begin
                            // Roll back to the last commit so no partial frame survives.
                            wr_ptr <= commit_ptr;
                            if (frame_end) begin
                                word_cnt <= '0;
                                state    <= after_frame;
                            end else begin
                                word_cnt <= word_cnt + CW'(1);
                                state    <= DROP;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                            if (frame_end) begin
                                commit_ptr <= wr_ptr + PW'(1);
                                word_cnt   <= '0;
                                state      <= after_frame;
                            end else begin
                                word_cnt <= word_cnt + CW'(1);
                            end
                        end
                    end
                end
                DROP: begin
                    if (word_done) begin
                        if (frame_end) begin
                            word_cnt <= '0;
                            state    <= after_frame;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A drop in the same cycle as clear_status takes priority over the clear.
            if (word_done && (state == RUN) && fifo_full) begin
                drop_cnt        <= clear_status ? 16'd1 : sat_inc16(drop_cnt);
                overflow_sticky <= 1'b1;
            end else if (clear_status) begin
                drop_cnt        <= '0;
                overflow_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer with 4-word frames and an 8-word FIFO.
module tb_adc_frame_packer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [11:0] data_in;
    logic        data_valid_in;
    logic        clear_status;
    logic [15:0] drop_cnt;
    logic        overflow_sticky;

    adc_frame_packer_if axis ();

    adc_frame_packer #(
        .DATA_WIDTH (12),
        .FRAME_WORDS(4),
        .FIFO_DEPTH (8)
    ) dut (
        .dco_div4       (clk),
        .rst            (rst),
        .enable         (enable),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .m_axis         (axis),
        .drop_cnt       (drop_cnt),
        .overflow_sticky(overflow_sticky),
        .clear_status   (clear_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: committed words queue up in exp_q, the open frame in pend_q.
    typedef enum {M_IDLE, M_RUN, M_DROP} mstate_t;
    logic [32:0] exp_q [$];
    logic [32:0] pend_q [$];
    mstate_t     m_state;
    int          m_wcnt;
    bit          m_half;
    logic [11:0] m_even;
    int          m_occ;
    logic [31:0] m_word;
    bit          m_last;
    bit          m_drop;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            pend_q.delete();
            m_state = M_IDLE;
            m_half  = 1'b0;
            m_wcnt  = 0;
        end else begin
            m_occ = exp_q.size() + pend_q.size();
            if (exp_q.size() != 0 && axis.tready) void'(exp_q.pop_front());
            if (m_state == M_IDLE) begin
                if (enable) m_state = M_RUN;
            end else if (data_valid_in) begin
                if (!m_half) begin
                    m_even = data_in;
                    m_half = 1'b1;
                end else begin
                    m_half = 1'b0;
                    m_word = {4'h0, data_in, 4'h0, m_even};
                    m_last = (m_wcnt == 3);
                    m_drop = (m_state == M_RUN) && (m_occ >= 8);
                    if (m_drop) begin
                        pend_q.delete();
                    end else if (m_state == M_RUN) begin
                        pend_q.push_back({m_last, m_word});
                        if (m_last) begin
                            foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
                            pend_q.delete();
                        end
                    end
                    if (m_last) begin
                        m_wcnt  = 0;
                        m_state = enable ? M_RUN : M_IDLE;
                    end else begin
                        m_wcnt = m_wcnt + 1;
                        if (m_drop) m_state = M_DROP;
                    end
                end
            end
        end
    end

    // Advance one cycle and compare the stream against the scoreboard head.
    task automatic step();
        @(negedge clk);
        check_vec("tvalid", axis.tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0 && axis.tvalid)
            check_vec("beat", {axis.tlast, axis.tdata}, exp_q[0]);
    endtask

    task automatic send_frame(input int base, input bit gappy, input int clr_idx);
        for (int i = 0; i < 8; i++) begin
            data_in       = 12'(base + i);
            data_valid_in = 1'b1;
            clear_status  = (i == clr_idx);
            step();
            clear_status  = 1'b0;
            if (gappy && (i % 2 == 1)) begin
                data_valid_in = 1'b0;
                step();
            end
        end
        data_valid_in = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        enable        = 1'b0;
        data_in       = '0;
        data_valid_in = 1'b0;
        clear_status  = 1'b0;
        axis.tready   = 1'b0;
        run(2);
        check_vec("rst_tvalid", axis.tvalid, 0);
        check_vec("rst_tlast", axis.tlast, 0);
        check_vec("rst_tdata", axis.tdata, 0);
        check_vec("rst_drop_cnt", drop_cnt, 0);
        check_vec("rst_sticky", overflow_sticky, 0);

        // Samples while idle must be ignored.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in       = 12'hAAA;
            data_valid_in = 1'b1;
            step();
        end
        data_valid_in = 1'b0;
        enable        = 1'b1;
        axis.tready   = 1'b1;
        step();

        // Basic frame
        send_frame(1, 1'b0, -1);
        check_vec("basic_first_tvalid", axis.tvalid, 1);
        check_vec("basic_first_tdata", axis.tdata, 32'h00020001);
        run(6);

        // Gearbox cadence 1,1,0
        send_frame(1, 1'b1, -1);
        run(6);

        // Backpressure: two frames fill the FIFO, the third is dropped
        axis.tready = 1'b0;
        send_frame(1, 1'b0, -1);
        send_frame(9, 1'b0, -1);
        check_vec("bp_tvalid", axis.tvalid, 1);
        check_vec("bp_tdata_hold", axis.tdata, 32'h00020001);
        send_frame(17, 1'b0, -1);
        check_vec("bp_drop_cnt", drop_cnt, 1);
        check_vec("bp_sticky", overflow_sticky, 1);
        check_vec("bp_tdata_after_drop", axis.tdata, 32'h00020001);
        axis.tready = 1'b1;
        run(12);
        check_vec("bp_drained", axis.tvalid, 0);

        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        check_vec("clr_drop_cnt", drop_cnt, 0);
        check_vec("clr_sticky", overflow_sticky, 0);

        // Overflow mid-frame: 6 committed words, new frame overflows on word 3
        axis.tready = 1'b0;
        send_frame(12'h020, 1'b0, -1);
        send_frame(12'h028, 1'b0, -1);
        axis.tready = 1'b1;
        run(2);
        axis.tready = 1'b0;
        send_frame(12'h040, 1'b0, -1);
        check_vec("mid_drop_cnt", drop_cnt, 1);
        axis.tready = 1'b1;
        send_frame(12'h050, 1'b0, -1);
        run(12);
        check_vec("mid_drained", axis.tvalid, 0);

        // Enable drops mid-frame: frame still commits, then idle ignores samples
        for (int i = 0; i < 8; i++) begin
            if (i == 4) enable = 1'b0;
            data_in       = 12'(12'h100 + i);
            data_valid_in = 1'b1;
            step();
        end
        for (int i = 0; i < 5; i++) begin
            data_in = 12'(12'h7F0 + i);
            step();
        end
        data_valid_in = 1'b0;
        run(4);
        check_vec("en_idle_empty", axis.tvalid, 0);
        enable = 1'b1;
        step();
        send_frame(12'h200, 1'b0, -1);
        run(6);

        // clear_status coincident with a drop: drop wins
        axis.tready = 1'b0;
        send_frame(12'h300, 1'b0, -1);
        send_frame(12'h308, 1'b0, -1);
        send_frame(12'h310, 1'b0, 1);
        check_vec("coinc_drop_cnt", drop_cnt, 1);
        check_vec("coinc_sticky", overflow_sticky, 1);
        axis.tready = 1'b1;
        run(12);

        // Saturation: preload the counter close to the top, then drop 5 frames
        axis.tready = 1'b0;
        send_frame(12'h400, 1'b0, -1);
        send_frame(12'h408, 1'b0, -1);
        force dut.drop_cnt = 16'hFFFB;
        #1;
        release dut.drop_cnt;
        send_frame(12'h410, 1'b0, -1);
        check_vec("sat_first_inc", drop_cnt, 16'hFFFC);
        for (int f = 0; f < 3; f++) send_frame(12'h420 + 8 * f, 1'b0, -1);
        check_vec("sat_reach", drop_cnt, 16'hFFFF);
        send_frame(12'h440, 1'b0, -1);
        check_vec("sat_hold", drop_cnt, 16'hFFFF);
        axis.tready = 1'b1;
        run(12);

        // Reset during a partial frame with committed data pending
        axis.tready = 1'b0;
        send_frame(12'h500, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            data_in       = 12'(12'h508 + i);
            data_valid_in = 1'b1;
            step();
        end
        data_valid_in = 1'b0;
        rst = 1'b1;
        step();
        check_vec("rst_mid_tvalid", axis.tvalid, 0);
        check_vec("rst_mid_drop_cnt", drop_cnt, 0);
        check_vec("rst_mid_sticky", overflow_sticky, 0);
        rst = 1'b0;
        step();
        axis.tready = 1'b1;
        send_frame(12'h600, 1'b0, -1);
        run(8);
        check_vec("final_drained", axis.tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Sits directly downstream of the 12-to-8 ADC gearbox in the main_ADC IP, in the same dco_div4 domain.
- Consumes the gearbox's `data_out`/`data_valid_out` word stream and packs sample pairs into 32-bit words.
- Groups words into fixed-length frames and buffers them in a commit-pointer FIFO.
- Presents only complete frames on an AXI4-Stream master port.
- A frame that overflows the FIFO is discarded whole and counted, so downstream never sees a partial frame.

Parameters:
- DATA_WIDTH, 12, sample width from the gearbox; legal range 1..16.
- FRAME_WORDS, 256, 32-bit words per frame (2*FRAME_WORDS samples); must be >= 2.
- FIFO_DEPTH, 1024, FIFO depth in 32-bit words; power of 2, >= FRAME_WORDS.

Ports:
- dco_div4  in  1  sole clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable, acted on only at frame boundaries.
- data_in  in  DATA_WIDTH  sample from the gearbox.
- data_valid_in  in  1  data_in valid this cycle.
- m_axis_tdata  out  32  packed word {pad16(s_odd), pad16(s_even)}, each sample zero-extended to 16 bits.
- m_axis_tvalid  out  1  committed word available.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last word of frame.
- drop_cnt  out  16  dropped-frame count, saturating at 16'hFFFF.
- overflow_sticky  out  1  set on any drop.
- clear_status  in  1  clears drop_cnt and overflow_sticky.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; half, word_cnt, wr_ptr, commit_ptr, rd_ptr all 0.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, drop_cnt=0, overflow_sticky=0.
  - Reset mid-frame or mid-transfer discards all FIFO contents, committed or not.
- States: IDLE, RUN, DROP.
  - IDLE: samples ignored, half held at 0. enable=1 moves to RUN next cycle; samples accepted from that cycle.
  - RUN: each data_valid_in=1 with half=0 stores s_even and sets half=1. The next valid sample completes a word and clears half.
  - A completed word is written at wr_ptr with last=(word_cnt==FRAME_WORDS-1); word_cnt increments and wraps to 0 after the last word.
  - On writing the last word, commit_ptr<=wr_ptr+1. If enable=0 at that cycle go to IDLE, else stay in RUN.
- Full: occupancy = wr_ptr-rd_ptr (pointers one bit wider than the address), evaluated before the current cycle's read. A word completing while occupancy==FIFO_DEPTH is an overflow, even if a read happens in the same cycle.
- Overflow response:
  - wr_ptr<=commit_ptr, discarding the partial frame.
  - drop_cnt increments (saturating) and overflow_sticky<=1.
  - If the overflowing word was the frame-last word: word_cnt<=0 and go to RUN, or IDLE if enable=0.
  - Otherwise go to DROP.
- DROP: keeps pairing samples and advancing word_cnt with no FIFO writes. On completing the frame-last word: word_cnt<=0 and go to RUN, or IDLE if enable=0. Further drops are not counted while in DROP.
- Read side:
  - m_axis_tvalid = (rd_ptr != commit_ptr); uncommitted words are never visible.
  - tdata/tlast are first-word-fall-through from the FIFO at rd_ptr, registered, and stable while tvalid=1 and tready=0.
  - rd_ptr increments when tvalid and tready are both 1.
- Latency: the commit edge is the edge that writes the frame-last word. m_axis_tvalid for that frame's first word rises in the cycle after it, with no extra delay. After that, one word is delivered per cycle while tready=1.
- Simultaneous events:
  - A write to the same cycle's read address is legal; the read returns the old committed word.
  - clear_status and a drop in the same cycle: the drop wins, giving drop_cnt=1 and sticky=1.
- Samples arriving with half=1 when the FSM enters IDLE cannot occur, because frames always end on a completed pair.

Test Plan (bench uses FRAME_WORDS=4, FIFO_DEPTH=8, DATA_WIDTH=12):
- Basic frame:
  - Stimulus: enable=1, tready=1, samples 0x001..0x008 on consecutive valid cycles.
  - Required: 4 words 0x00020001, 0x00040003, 0x00060005, 0x00080007; tlast on the 4th only; tvalid rises the cycle after the commit edge.
- Gappy input: same 8 samples with valid in a 1,1,0 repeating pattern (gearbox cadence) -> identical output words; no word becomes visible before the 8th sample is accepted.
- Backpressure:
  - Stimulus: tready=0, two frames (16 samples).
  - Required: occupancy 8, tvalid=1, tdata held at 0x00020001.
  - Then a third frame: drop_cnt=1, overflow_sticky=1, FIFO still holds exactly 8 words.
  - Releasing tready yields frames 1 and 2 intact, with tlast on words 4 and 8.
- Overflow mid-frame:
  - Stimulus: start with 6 committed words, tready=0, then a new frame.
  - Required: word 3 of the new frame overflows -> wr_ptr rolled back, state DROP, word 4 not written.
  - The following frame, with tready=1, is accepted whole.
- Enable timing: deassert enable mid-frame -> the frame completes and commits, then IDLE; samples are ignored until enable=1 again.
- Reset/status:
  - rst during a partial frame with committed data -> tvalid=0 next cycle and drop_cnt=0.
  - clear_status with a coincident drop -> drop_cnt=1.
  - 65540 drops -> drop_cnt=16'hFFFF.
